// File: rtl/timer_ctrl_pkg.sv
// Shared types and register map for the timer_controller peripheral.
// Periodic reload is compiled in only when TIMER_CTRL_PERIODIC_EN is defined.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_EXPCNT = 2'd3;

  // CTRL write actions
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_STOP     = 1;
  localparam int unsigned CTRL_PERIODIC = 2;
  localparam int unsigned CTRL_ACK      = 3;

  // CTRL read status
  localparam int unsigned CTRL_RUNNING  = 0;
  localparam int unsigned CTRL_DONE     = 1;
  localparam int unsigned CTRL_IRQ      = 3;

endpackage

// File: rtl/timer_controller_if.sv
// CPU register bus of the timer_controller peripheral.
interface timer_controller_if #(
  parameter int unsigned P_WIDTH = 16
);
  logic               I_WE;
  logic [1:0]         I_ADDR;
  logic [P_WIDTH-1:0] I_WDATA;
  logic [P_WIDTH-1:0] O_RDATA;
  logic               O_IRQ;
  logic               O_RUNNING;

  modport master (
    output I_WE, I_ADDR, I_WDATA,
    input  O_RDATA, O_IRQ, O_RUNNING
  );

  modport slave (
    input  I_WE, I_ADDR, I_WDATA,
    output O_RDATA, O_IRQ, O_RUNNING
  );
endinterface

// File: rtl/timer_controller_tick_prescaler.sv
// Clock divider: one-cycle O_TICK each P_CLK_CYCLES_PER_TICK enabled cycles.
module tick_prescaler #(
  parameter int unsigned P_CLK_CYCLES_PER_TICK = 50
) (
  input  logic I_CLK,
  input  logic I_NRESET,
  input  logic I_CLEAR,
  input  logic I_ENABLE,
  output logic O_TICK
);

  localparam int unsigned CNT_W =
    (P_CLK_CYCLES_PER_TICK > 2) ? $clog2(P_CLK_CYCLES_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CLK_CYCLES_PER_TICK - 1);

  logic [CNT_W-1:0] cnt_q;

  assign O_TICK = I_ENABLE && (cnt_q == CNT_LAST);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      cnt_q <= '0;
    end else if (I_CLEAR) begin
      cnt_q <= '0;
    end else if (I_ENABLE) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Memory-mapped down-count timer with sticky expiry interrupt and expiry counter.
// Define TIMER_CTRL_PERIODIC_EN to implement the PERIODIC auto-reload mode.
module timer_controller
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned P_CLK_CYCLES_PER_TICK = 50,
  parameter int unsigned P_WIDTH               = 16
) (
  input  logic              I_CLK,
  input  logic              I_NRESET,
  timer_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE = STATE_IDLE;
  localparam logic [1:0] ST_RUN  = STATE_RUN;
  localparam logic [1:0] ST_DONE = STATE_DONE;

  logic [1:0]         state_q, state_d;
  logic [P_WIDTH-1:0] load_q, load_d;
  logic [P_WIDTH-1:0] count_q, count_d;
  logic [P_WIDTH-1:0] expcnt_q, expcnt_d;
  logic [P_WIDTH-1:0] rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic               running_q;
  logic               periodic_q;
  logic               tick, presc_clear, expire;
  logic               ctrl_wr, cmd_start, cmd_stop, cmd_ack;

  assign ctrl_wr   = bus.I_WE && (bus.I_ADDR == ADDR_CTRL);
  assign cmd_start = ctrl_wr && bus.I_WDATA[CTRL_START];
  assign cmd_stop  = ctrl_wr && bus.I_WDATA[CTRL_STOP];
  assign cmd_ack   = ctrl_wr && bus.I_WDATA[CTRL_ACK];

  tick_prescaler #(
    .P_CLK_CYCLES_PER_TICK(P_CLK_CYCLES_PER_TICK)
  ) u_prescaler (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .I_CLEAR  (presc_clear),
    .I_ENABLE (state_q == ST_RUN),
    .O_TICK   (tick)
  );

`ifdef TIMER_CTRL_PERIODIC_EN
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET)    periodic_q <= 1'b0;
    else if (ctrl_wr) periodic_q <= bus.I_WDATA[CTRL_PERIODIC];
  end
`else
  assign periodic_q = 1'b0;
`endif

  // Next-state: STOP beats START, START beats a pending tick.
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    count_d     = count_q;
    expcnt_d    = expcnt_q;
    irq_d       = irq_q;
    presc_clear = 1'b0;
    expire      = 1'b0;

    if (cmd_ack) irq_d = 1'b0;
    if (bus.I_WE && (bus.I_ADDR == ADDR_LOAD)) load_d = bus.I_WDATA;

    if (cmd_stop) begin
      if (state_q == ST_RUN) state_d = ST_IDLE;
    end else if (cmd_start) begin
      count_d     = load_q;
      presc_clear = 1'b1;
      if (load_q == '0) begin
        state_d = ST_DONE;
        expire  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_RUN) && tick) begin
      if (count_q > P_WIDTH'(1)) begin
        count_d = count_q - P_WIDTH'(1);
      end else begin
        expire = 1'b1;
        if (periodic_q) begin
          count_d = load_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end

    // Expiry overrides a same-cycle ACK; an EXPCNT write overrides the increment.
    if (expire) begin
      irq_d = 1'b1;
      if (expcnt_q != '1) expcnt_d = expcnt_q + P_WIDTH'(1);
    end
    if (bus.I_WE && (bus.I_ADDR == ADDR_EXPCNT)) expcnt_d = '0;
  end

  always_comb begin
    rdata_d = '0;
    case (bus.I_ADDR)
      ADDR_CTRL: begin
        rdata_d[CTRL_RUNNING]  = (state_q == ST_RUN);
        rdata_d[CTRL_DONE]     = (state_q == ST_DONE);
        rdata_d[CTRL_PERIODIC] = periodic_q;
        rdata_d[CTRL_IRQ]      = irq_q;
      end
      ADDR_LOAD:   rdata_d = load_q;
      ADDR_COUNT:  rdata_d = count_q;
      ADDR_EXPCNT: rdata_d = expcnt_q;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q   <= ST_IDLE;
      load_q    <= '0;
      count_q   <= '0;
      expcnt_q  <= '0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expcnt_q  <= expcnt_d;
      irq_q     <= irq_d;
      running_q <= (state_d == ST_RUN);
      rdata_q   <= rdata_d;
    end
  end

  assign bus.O_RDATA   = rdata_q;
  assign bus.O_IRQ     = irq_q;
  assign bus.O_RUNNING = running_q;

endmodule
